mem_access_sequencer: RTL and testbench
=======================================

// Module: mem_access_sequencer
// PURPOSE
//  Multi-cycle sequencer between the single-cycle controller and the data memory/cache.
//  - Turns one-cycle load/store decode pulses into a MemRead/MemWrite access.
//  - Honours the memory busy handshake and freezes the PC (stall) until the access retires.
//  - Defers interrupts so they are taken only between accesses.
//  - Aborts hung accesses after a programmable timeout.
// PARAMETERS
//  NBITS    8   data/address width, same as controller datapath
//  TIMEOUT  15  max WAIT cycles with busy=1 before abort (>=1)
// PORTS
//  clock      in   1      system clock; single clock domain
//  reset      in   1      synchronous, active-high reset
//  ld         in   1      decode: current instruction is a load (valid when stall=0)
//  st         in   1      decode: current instruction is a store (valid when stall=0)
//  addr       in   NBITS  ALU-computed effective address
//  wdata      in   NBITS  store data (RS2 value)
//  MemRead    out  1      read strobe to memory/cache
//  MemWrite   out  1      write strobe to memory/cache
//  mem_addr   out  NBITS  latched address to memory
//  mem_wdata  out  NBITS  latched store data to memory
//  busy       in   1      memory not ready; sampled only in WAIT
//  mem_rdata  in   NBITS  memory read data; valid when busy=0 in WAIT
//  stall      out  1      freeze PC/pipeline; combinational
//  rdata      out  NBITS  load result for the RD write-back mux
//  rvalid     out  1      one-cycle pulse: rdata valid, RegWrite allowed for the load
//  interrupt  in   1      external interrupt request (level or pulse)
//  irq_take   out  1      one-cycle pulse: controller must vector now (saves sepc)
//  err        out  1      one-cycle pulse: timeout or illegal ld&st
// BEHAVIOUR
//  - FSM states: IDLE, ISSUE, WAIT, DONE. All outputs except stall are registered.
//  - Reset:
//    - state=IDLE; MemRead=MemWrite=rvalid=irq_take=err=0.
//    - mem_addr=mem_wdata=rdata=0; irq_pending=0; wait counter=0.
//    - stall=0 while reset is high.
//  - IDLE:
//    - ld=1,st=0: latch addr, set dir=read, go ISSUE.
//    - st=1,ld=0: latch addr and wdata, set dir=write, go ISSUE.
//    - ld=1,st=1: no access; err pulses next cycle; stay IDLE.
//  - stall = ~reset & ((state==IDLE & (ld|st)) | state==ISSUE | state==WAIT).
//    - stall is high in the request cycle itself.
//    - stall is low in DONE, so the PC advances exactly once per memory instruction.
//  - ISSUE: MemRead (read) or MemWrite (write) goes high; clear counter; go WAIT.
//  - WAIT: strobe stays asserted while busy=1.
//    - busy=0: read captures mem_rdata into rdata; go DONE; strobe drops in DONE.
//    - busy=1: counter++. At counter==TIMEOUT: go DONE with err=1, rvalid=0, rdata unchanged.
//  - DONE: strobes low; rvalid=1 for a successful read only; go IDLE next cycle.
//    - ld/st are ignored in DONE; the next access starts from IDLE.
//  - Minimum latency with busy=0: request in cycle 0 (IDLE), ISSUE in cycle 1, WAIT in cycle 2, DONE in cycle 3.
//    - stall is high for 3 cycles.
//  - Interrupt handling:
//    - interrupt=1 in any cycle sets irq_pending (sticky).
//    - irq_take pulses in the cycle after state==IDLE with irq_pending=1 and ld=st=0; irq_pending clears.
//    - If ld|st and irq_pending coincide in IDLE, the access wins; the interrupt waits for the next IDLE.
//    - interrupt arriving in the same cycle irq_take is issued re-arms irq_pending.
//  - Counter width: $clog2(TIMEOUT+1); saturates and never wraps.
//  - Reset mid-access: next state is IDLE; strobes low the next cycle.
//    - No rvalid/err pulse is generated; the pending interrupt is dropped.
//  - busy changing while not in WAIT is ignored.
// TESTING
//  - Load, busy=0: ld=1, addr=8'h10, mem_rdata=8'hA5 -> MemRead high cycles 1-2, stall high cycles 0-2, rvalid=1 and rdata=8'hA5 in cycle 3.
//  - Store, busy 4 cycles: st=1, addr=8'h20, wdata=8'h3C -> MemWrite held 5 cycles, mem_wdata=8'h3C, stall released the cycle after busy falls, no rvalid.
//  - Timeout: TIMEOUT=15, busy stuck 1 -> err pulse exactly 16 cycles after ISSUE, MemRead low in DONE, rvalid=0.
//  - Interrupt during a load: interrupt pulse in WAIT -> no irq_take until the FSM is back in IDLE; one irq_take pulse; no duplicate pulse.
//  - Simultaneous ld&st: ld=st=1 in IDLE -> err pulse, MemRead=MemWrite=0, stall=1 for that cycle only.
//  - Reset mid-WAIT: reset=1 with busy=1 -> all outputs 0 the next cycle, state=IDLE, a subsequent load completes normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: turns load/store decode pulses into a stalled, timed-out memory access with deferred interrupts
module mem_access_sequencer #(
    parameter int NBITS   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ld,
    input  logic             st,
    input  logic [NBITS-1:0] addr,
    input  logic [NBITS-1:0] wdata,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [NBITS-1:0] mem_addr,
    output logic [NBITS-1:0] mem_wdata,
    input  logic             busy,
    input  logic [NBITS-1:0] mem_rdata,
    output logic             stall,
    output logic [NBITS-1:0] rdata,
    output logic             rvalid,
    input  logic             interrupt,
    output logic             irq_take,
    output logic             err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_n;
    logic          dir, dir_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          irq_pending;
    logic          start, rd_ok, expired, take;

    assign start   = state == IDLE && (ld ^ st);
    assign rd_ok   = state == WAIT && !busy && dir;
    assign expired = state == WAIT && busy && cnt == CW'(TIMEOUT - 1);
    assign take    = state == IDLE && irq_pending && !ld && !st;
    assign stall   = !reset && ((state == IDLE && (ld || st)) || state == ISSUE || state == WAIT);

    // State, direction and wait-counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            dir   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            dir   <= dir_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: the wait counter saturates so a stuck busy can never wrap it
    always_comb begin
        state_n = state;
        dir_n   = dir;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                state_n = start ? ISSUE : IDLE;
                dir_n   = start ? ld : dir;
            end
            ISSUE: begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: begin
                state_n = (!busy || expired) ? DONE : WAIT;
                cnt_n   = (busy && cnt != CW'(TIMEOUT)) ? cnt + 1'b1 : cnt;
            end
            DONE: state_n = IDLE;
        endcase
    end

    // Registered outputs, computed from the state being entered so strobes line up with ISSUE/WAIT
    always_ff @(posedge clock) begin
        if (reset) begin
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            rvalid      <= 1'b0;
            err         <= 1'b0;
            irq_take    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            MemRead     <= (state_n == ISSUE || state_n == WAIT) && dir_n;
            MemWrite    <= (state_n == ISSUE || state_n == WAIT) && !dir_n;
            mem_addr    <= start ? addr : mem_addr;
            mem_wdata   <= (start && st) ? wdata : mem_wdata;
            rdata       <= rd_ok ? mem_rdata : rdata;
            rvalid      <= rd_ok;
            err         <= (state == IDLE && ld && st) || expired;
            irq_take    <= take;
            irq_pending <= interrupt || (irq_pending && !take);
        end
    end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: table-driven cycle vectors plus timeout and reset-mid-access sequences
module tb_mem_access_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ld = 1'b0, st = 1'b0, busy = 1'b0, interrupt = 1'b0;
    logic [7:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic       MemRead, MemWrite, stall, rvalid, irq_take, err;
    logic [7:0] mem_addr, mem_wdata, rdata;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] ctl;
        logic [7:0] a, w, m;
        logic [5:0] flg;
        logic [7:0] rd, ma, mw;
    } vec_t;

    vec_t vq[$];

    mem_access_sequencer #(.NBITS(8), .TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .ld(ld), .st(st), .addr(addr), .wdata(wdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .mem_rdata(mem_rdata), .stall(stall), .rdata(rdata), .rvalid(rvalid),
        .interrupt(interrupt), .irq_take(irq_take), .err(err)
    );

    always #5 clock = ~clock;

    task automatic add(input logic [4:0] c, input logic [7:0] a, w, m,
                       input logic [5:0] f, input logic [7:0] rd, ma, mw);
        vec_t v;
        v.ctl = c; v.a = a; v.w = w; v.m = m;
        v.flg = f; v.rd = rd; v.ma = ma; v.mw = mw;
        vq.push_back(v);
    endtask

    task automatic cyc(input logic r, l, s, b, i, input logic [7:0] a, w, m);
        @(posedge clock);
        #1;
        reset = r; ld = l; st = s; busy = b; interrupt = i;
        addr = a; wdata = w; mem_rdata = m;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    initial begin
        // ctl = {reset, ld, st, busy, interrupt}; flg = {MemRead, MemWrite, stall, rvalid, err, irq_take}
        add(5'b11000, 8'h10, 8'h00, 8'h00, 6'b000000, 8'h00, 8'h00, 8'h00);
        add(5'b10000, 8'h00, 8'h00, 8'h00, 6'b000000, 8'h00, 8'h00, 8'h00);
        add(5'b01000, 8'h10, 8'h00, 8'hA5, 6'b001000, 8'h00, 8'h00, 8'h00);
        add(5'b00000, 8'h10, 8'h00, 8'hA5, 6'b101000, 8'h00, 8'h10, 8'h00);
        add(5'b00000, 8'h00, 8'h00, 8'hA5, 6'b101000, 8'h00, 8'h10, 8'h00);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000100, 8'hA5, 8'h10, 8'h00);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000000, 8'hA5, 8'h10, 8'h00);
        add(5'b01100, 8'h77, 8'h00, 8'h00, 6'b001000, 8'hA5, 8'h10, 8'h00);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000010, 8'hA5, 8'h10, 8'h00);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000000, 8'hA5, 8'h10, 8'h00);
        add(5'b00100, 8'h20, 8'h3C, 8'h00, 6'b001000, 8'hA5, 8'h10, 8'h00);
        add(5'b00010, 8'h00, 8'h00, 8'h00, 6'b011000, 8'hA5, 8'h20, 8'h3C);
        add(5'b00010, 8'h00, 8'h00, 8'h00, 6'b011000, 8'hA5, 8'h20, 8'h3C);
        add(5'b00010, 8'h00, 8'h00, 8'h00, 6'b011000, 8'hA5, 8'h20, 8'h3C);
        add(5'b00010, 8'h00, 8'h00, 8'h00, 6'b011000, 8'hA5, 8'h20, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h99, 6'b011000, 8'hA5, 8'h20, 8'h3C);
        add(5'b01000, 8'h55, 8'h00, 8'h00, 6'b000000, 8'hA5, 8'h20, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000000, 8'hA5, 8'h20, 8'h3C);
        add(5'b01000, 8'h30, 8'h00, 8'h5A, 6'b001000, 8'hA5, 8'h20, 8'h3C);
        add(5'b00010, 8'h00, 8'h00, 8'h00, 6'b101000, 8'hA5, 8'h30, 8'h3C);
        add(5'b00011, 8'h00, 8'h00, 8'h00, 6'b101000, 8'hA5, 8'h30, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h5A, 6'b101000, 8'hA5, 8'h30, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000100, 8'h5A, 8'h30, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000000, 8'h5A, 8'h30, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000001, 8'h5A, 8'h30, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000000, 8'h5A, 8'h30, 8'h3C);
        add(5'b00001, 8'h00, 8'h00, 8'h00, 6'b000000, 8'h5A, 8'h30, 8'h3C);
        add(5'b01000, 8'h40, 8'h00, 8'h00, 6'b001000, 8'h5A, 8'h30, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b101000, 8'h5A, 8'h40, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h11, 6'b101000, 8'h5A, 8'h40, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000100, 8'h11, 8'h40, 8'h3C);
        add(5'b00001, 8'h00, 8'h00, 8'h00, 6'b000000, 8'h11, 8'h40, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000001, 8'h11, 8'h40, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000001, 8'h11, 8'h40, 8'h3C);
        add(5'b00000, 8'h00, 8'h00, 8'h00, 6'b000000, 8'h11, 8'h40, 8'h3C);

        foreach (vq[k]) begin
            cyc(vq[k].ctl[4], vq[k].ctl[3], vq[k].ctl[2], vq[k].ctl[1], vq[k].ctl[0],
                vq[k].a, vq[k].w, vq[k].m);
            chk($sformatf("vec%0d", k),
                {MemRead, MemWrite, stall, rvalid, err, irq_take, rdata, mem_addr, mem_wdata},
                {vq[k].flg, vq[k].rd, vq[k].ma, vq[k].mw});
        end

        cyc(0, 1, 0, 0, 0, 8'h50, 8'h00, 8'h00);
        chk("to_req_stall", stall, 1);
        for (int k = 1; k <= 16; k++) begin
            cyc(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
            chk($sformatf("to_wait%0d", k), {MemRead, err, stall, rvalid}, 4'b1010);
        end
        cyc(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        chk("to_abort", {MemRead, err, rvalid, stall, rdata, mem_addr}, {4'b0100, 8'h11, 8'h50});
        cyc(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        chk("to_after", {MemRead, err, stall}, 3'b000);

        cyc(0, 1, 0, 0, 0, 8'h60, 8'h00, 8'h00);
        chk("rst_req", stall, 1);
        cyc(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        chk("rst_issue", MemRead, 1);
        cyc(0, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00);
        cyc(1, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        chk("rst_stall_low", stall, 0);
        cyc(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
        chk("rst_outputs",
            {MemRead, MemWrite, stall, rvalid, err, irq_take, rdata, mem_addr, mem_wdata}, 0);
        cyc(0, 1, 0, 0, 0, 8'h70, 8'h00, 8'hC3);
        chk("rst_irq_dropped", {irq_take, stall}, 2'b01);
        cyc(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hC3);
        chk("rst_reload_issue", {MemRead, mem_addr}, {1'b1, 8'h70});
        cyc(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hC3);
        cyc(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        chk("rst_reload_done", {rvalid, stall, MemRead, irq_take, rdata}, {4'b1000, 8'hC3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
